port_frame_arbiter: RTL
=======================

PORT_FRAME_ARBITER -- requirements
Module: port_frame_arbiter

Interface
REQ-001 SHALL have parameter: ports, 4, number of requesters (2..8).
REQ-002 SHALL have parameter: parrallelWidth, 512, data word width.
REQ-003 SHALL have port: clk  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: reqValid  input  ports  per-requester word valid.
REQ-006 SHALL have port: reqData  input  ports*parrallelWidth  requester i data at slice [i*parrallelWidth +: parrallelWidth].
REQ-007 SHALL have port: reqInfo  input  ports x info_type  per-requester info (startOfFrame, endOfFrame, length).
REQ-008 SHALL have port: reqReady  output  ports  word accepted from requester i this cycle.
REQ-009 SHALL have port: push  output  1  write strobe to converter FIFO.
REQ-010 SHALL have port: pushData  output  parrallelWidth  muxed data.
REQ-011 SHALL have port: pushInfo  output  info_type  muxed info.
REQ-012 SHALL have port: full  input  1  converter FIFO full; backpressure.
REQ-013 SHALL have port: grant  output  ports  one-hot owner, all-zero when idle.
REQ-014 SHALL have port: frameDone  output  1  one-cycle pulse when an endOfFrame word is pushed.

Function
REQ-015 SHALL implement two states: IDLE and LOCKED.
REQ-016 In IDLE, SHALL select winner among reqValid by round-robin, searching upward from pointer rrPtr with wrap at ports-1 -> 0.
REQ-017 In IDLE with any reqValid, SHALL register grant = winner one-hot and enter LOCKED next cycle; no transfer in the IDLE cycle.
REQ-018 In IDLE with no reqValid, SHALL remain IDLE, grant = 0.
REQ-019 In LOCKED, push SHALL equal reqValid[owner] && !full, combinationally.
REQ-020 reqReady[owner] SHALL equal push; reqReady of all non-owners SHALL be 0.
REQ-021 pushData/pushInfo SHALL be reqData/reqInfo of owner when grant nonzero, else 0.
REQ-022 Ownership SHALL persist across cycles with reqValid[owner] low or full high; no preemption mid-frame.
REQ-023 When push && pushInfo.endOfFrame, SHALL pulse frameDone, set rrPtr = (owner+1) mod ports, return to IDLE, clear grant next cycle.
REQ-024 Single-word frame (startOfFrame and endOfFrame both set) SHALL follow REQ-023 on its one transfer.
REQ-025 First word transferred after grant without startOfFrame SHALL still be pushed unchanged; no frame repair.
REQ-026 full high SHALL suppress push and reqReady regardless of state; full SHALL NOT change state or owner.
REQ-027 Minimum gap between frames SHALL be one IDLE cycle (arbitration bubble); throughput per frame = words + 1 cycles when full low.
REQ-028 rrPtr width SHALL be $clog2(ports); wrap SHALL be explicit for non-power-of-two ports.

Reset
REQ-029 rst high at a rising edge SHALL force state IDLE, grant 0, rrPtr 0.
REQ-030 During and after reset, push, reqReady, frameDone, pushData, pushInfo SHALL be 0 until next grant.
REQ-031 Reset mid-frame SHALL abandon the frame; no endOfFrame is synthesized; next arbitration starts from rrPtr 0.

Verification
REQ-032 Single requester: reqValid=0001, 3-word frame, full=0 -> grant=0001 at cycle 1, push cycles 1-3, frameDone at cycle 3, grant=0 at cycle 4.
REQ-033 Contention: all four valid with 2-word frames from reset -> service order 0,1,2,3, each separated by one IDLE cycle; total 12 cycles.
REQ-034 Backpressure: full=1 for 5 cycles mid-frame of port 2 -> push=0, reqReady=0, grant stays 0100; resumes with next word, no loss or duplication.
REQ-035 Lock: port 1 owner, port 0 raises reqValid mid-frame -> port 0 not granted until port 1 endOfFrame pushed; then rrPtr=2, port 0 granted only if 2,3 idle.
REQ-036 Reset mid-frame: rst for one cycle during port 3 word 2 -> grant=0, state IDLE, rrPtr=0; port 0 wins if valid next.
REQ-037 Idle requester: owner drops reqValid for 4 cycles -> push=0, grant held, no frameDone.

Source files
------------

// File: rtl/port_frame_arbiter.sv
// Round-robin frame arbiter: grants one requester for a whole frame and forwards
// its words to a converter FIFO, honouring FIFO backpressure.
package port_frame_arbiter_pkg;
    localparam int unsigned LenW = 16;

    typedef struct packed {
        logic            startOfFrame;
        logic            endOfFrame;
        logic [LenW-1:0] length;
    } info_type;
endpackage

module port_frame_arbiter
    import port_frame_arbiter_pkg::*;
#(
    parameter int unsigned ports          = 4,
    parameter int unsigned parrallelWidth = 512
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ports-1:0]                reqValid,
    input  logic [ports*parrallelWidth-1:0] reqData,
    input  info_type [ports-1:0]            reqInfo,
    output logic [ports-1:0]                reqReady,
    output logic                            push,
    output logic [parrallelWidth-1:0]       pushData,
    output info_type                        pushInfo,
    input  logic                            full,
    output logic [ports-1:0]                grant,
    output logic                            frameDone
);
    localparam int unsigned PtrW = $clog2(ports);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e                                r_state;
    logic [ports-1:0]                      r_grant;
    logic [PtrW-1:0]                       r_owner;
    logic [PtrW-1:0]                       r_rrPtr;

    logic [ports-1:0][parrallelWidth-1:0]  w_words;
    logic [PtrW-1:0]                       w_winner;
    logic                                  w_hit;
    logic [PtrW-1:0]                       w_nextPtr;
    logic                                  w_active;
    logic                                  w_push;
    logic                                  w_eof;

    // Explicit wrap so non-power-of-two port counts never index past ports-1.
    function automatic logic [PtrW-1:0] wrap_idx(input int unsigned base,
                                                 input int unsigned off);
        int unsigned sum;
        sum = base + off;
        if (sum >= ports) sum = sum - ports;
        return PtrW'(sum);
    endfunction

    assign w_words = reqData;

    always_comb begin
        w_winner = r_rrPtr;
        w_hit    = 1'b0;
        for (int unsigned k = 0; k < ports; k++) begin
            if (!w_hit && reqValid[wrap_idx(32'(r_rrPtr), k)]) begin
                w_winner = wrap_idx(32'(r_rrPtr), k);
                w_hit    = 1'b1;
            end
        end
    end

    assign w_nextPtr = wrap_idx(32'(r_owner), 1);

    // Reset gates the datapath so nothing leaks out while rst is high.
    assign w_active  = (r_state == StLocked) && !rst;
    assign w_push    = w_active && reqValid[r_owner] && !full;
    assign w_eof     = pushInfo.endOfFrame;

    assign push      = w_push;
    assign reqReady  = w_push ? r_grant : '0;
    assign pushData  = w_active ? w_words[r_owner] : '0;
    assign pushInfo  = w_active ? reqInfo[r_owner] : '0;
    assign frameDone = w_push && w_eof;
    assign grant     = r_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_grant <= '0;
            r_owner <= '0;
            r_rrPtr <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (|reqValid) begin
                        r_state           <= StLocked;
                        r_owner           <= w_winner;
                        r_grant           <= '0;
                        r_grant[w_winner] <= 1'b1;
                    end
                end
                StLocked: begin
                    if (w_push && w_eof) begin
                        r_state <= StIdle;
                        r_grant <= '0;
                        r_rrPtr <= w_nextPtr;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end
endmodule
